// File: rtl/feature_width_conv_fifo_if.sv
// Bus bundle for feature_width_conv_fifo: flush, wide write port, narrow read port, skip and status.
interface feature_width_conv_fifo_if #(
    parameter int DATA_W     = 128,
    parameter int RATIO_LOG2 = 4,
    parameter int DEPTH_W    = 8,
    parameter int SKIP_W     = 10
);
    localparam int DATA_R = DATA_W >> RATIO_LOG2;
    localparam int CNT_W  = DEPTH_W + RATIO_LOG2 + 1;

    // Handshake: a write is taken on an edge where i_wren && !o_full; a read is taken where
    // i_rden && !o_empty && !i_skip, and its lane appears on o_rddata with o_rdvalid high for
    // exactly the following cycle. i_skip drops min(i_skip_num, o_count) read words at once.
    logic              i_clear;
    logic              i_wren;
    logic [DATA_W-1:0] i_wrdata;
    logic              i_rden;
    logic [DATA_R-1:0] o_rddata;
    logic              o_rdvalid;
    logic              i_skip;
    logic [SKIP_W-1:0] i_skip_num;
    logic              o_full;
    logic              o_almost_full;
    logic              o_empty;
    logic              o_almost_empty;
    logic [CNT_W-1:0]  o_count;

    modport master (
        output i_clear, i_wren, i_wrdata, i_rden, i_skip, i_skip_num,
        input  o_rddata, o_rdvalid, o_full, o_almost_full, o_empty, o_almost_empty, o_count
    );

    modport slave (
        input  i_clear, i_wren, i_wrdata, i_rden, i_skip, i_skip_num,
        output o_rddata, o_rdvalid, o_full, o_almost_full, o_empty, o_almost_empty, o_count
    );
endinterface

// File: rtl/feature_width_conv_fifo.sv
// Single-clock FIFO taking DATA_W-bit words and returning them as 2^RATIO_LOG2 narrower lanes,
// lane 0 first, with a bulk skip that discards read words without returning them.
module feature_width_conv_fifo #(
    parameter int DATA_W     = 128,
    parameter int RATIO_LOG2 = 4,
    parameter int DEPTH_W    = 8,
    parameter int AF_THRESH  = 2 ** (DEPTH_W - 1),
    parameter int AE_THRESH  = 64,
    parameter int SKIP_W     = 10
) (
    input  logic                      system_clk,
    input  logic                      rst,
    feature_width_conv_fifo_if.slave  bus
);
    localparam int DATA_R = DATA_W >> RATIO_LOG2;
    localparam int PTR_W  = DEPTH_W + RATIO_LOG2;
    localparam int CNT_W  = PTR_W + 1;
    localparam int WORDS  = 2 ** DEPTH_W;
    localparam int WIDE_W = CNT_W + SKIP_W;

    localparam logic [CNT_W-1:0] CAP       = {1'b1, {PTR_W{1'b0}}};
    localparam logic [CNT_W-1:0] RATIO     = CNT_W'(2 ** RATIO_LOG2);
    localparam logic [PTR_W-1:0] LANE_MASK = PTR_W'(2 ** RATIO_LOG2 - 1);
    localparam logic [CNT_W-1:0] AF_T      = CNT_W'(AF_THRESH);
    localparam logic [CNT_W-1:0] AE_T      = CNT_W'(AE_THRESH);

    logic [DATA_W-1:0]  mem [WORDS];
    logic [DEPTH_W-1:0] wrptr;
    logic [PTR_W-1:0]   rdptr;
    logic [CNT_W-1:0]   cnt;
    logic [CNT_W-1:0]   cnt_next;
    logic [CNT_W-1:0]   space;
    logic [CNT_W-1:0]   skip_n;
    logic [WIDE_W-1:0]  skip_wide;
    logic [WIDE_W-1:0]  cnt_wide;
    logic [PTR_W-1:0]   lane_idx;
    logic [DATA_R-1:0]  rd_lane;
    logic               full;
    logic               wr_acc;
    logic               rd_acc;
    logic               skip_acc;
    logic [DATA_R-1:0]  rddata_q;
    logic               rdvalid_q;
    logic               af_q;
    logic               ae_q;

    always_comb begin
        space     = CAP - cnt;
        full      = (space < RATIO);
        wr_acc    = bus.i_wren && !full && !bus.i_clear;
        rd_acc    = bus.i_rden && (cnt != '0) && !bus.i_skip && !bus.i_clear;
        skip_acc  = bus.i_skip && !bus.i_clear;
        skip_wide = WIDE_W'(bus.i_skip_num);
        cnt_wide  = WIDE_W'(cnt);
        // Skip amount is clamped against the pre-write occupancy, so a skip never eats same-cycle data.
        skip_n    = (skip_wide < cnt_wide) ? CNT_W'(skip_wide) : cnt;
        lane_idx  = rdptr & LANE_MASK;
        rd_lane   = DATA_R'(mem[rdptr[PTR_W-1 -: DEPTH_W]] >> (lane_idx * DATA_R));
        cnt_next  = cnt;
        if (bus.i_clear) begin
            cnt_next = '0;
        end else begin
            cnt_next = cnt + (wr_acc ? RATIO : '0) - (rd_acc ? CNT_W'(1) : '0)
                           - (skip_acc ? skip_n : '0);
        end
    end

    // Storage has no reset; occupancy alone decides what is valid.
    always_ff @(posedge system_clk) begin
        if (!rst && wr_acc) begin
            mem[wrptr] <= bus.i_wrdata;
        end
    end

    always_ff @(posedge system_clk) begin
        if (rst) begin
            wrptr     <= '0;
            rdptr     <= '0;
            cnt       <= '0;
            rddata_q  <= '0;
            rdvalid_q <= 1'b0;
            af_q      <= 1'b0;
            ae_q      <= 1'b1;
        end else begin
            cnt       <= cnt_next;
            rdvalid_q <= rd_acc;
            af_q      <= ((cnt_next >> RATIO_LOG2) >= AF_T);
            ae_q      <= (cnt_next < AE_T);
            if (rd_acc) begin
                rddata_q <= rd_lane;
            end
            if (bus.i_clear) begin
                wrptr <= '0;
                rdptr <= '0;
            end else begin
                if (wr_acc) begin
                    wrptr <= wrptr + DEPTH_W'(1);
                end
                // Truncation to PTR_W bits gives the modulo-CAP wrap, including a skip of exactly CAP.
                if (rd_acc) begin
                    rdptr <= rdptr + PTR_W'(1);
                end else if (skip_acc) begin
                    rdptr <= rdptr + PTR_W'(skip_n);
                end
            end
        end
    end

    assign bus.o_rddata       = rddata_q;
    assign bus.o_rdvalid      = rdvalid_q;
    assign bus.o_full         = full;
    assign bus.o_empty        = (cnt == '0);
    assign bus.o_almost_full  = af_q;
    assign bus.o_almost_empty = ae_q;
    assign bus.o_count        = cnt;
endmodule

// File: tb/tb_feature_width_conv_fifo.sv
// Directed bench for feature_width_conv_fifo: a lane-queue model feeds an expected-read queue
// that a negedge monitor drains whenever o_rdvalid is seen.
module tb_feature_width_conv_fifo;
  localparam int DATA_W     = 128;
  localparam int RATIO_LOG2 = 4;
  localparam int DEPTH_W    = 8;
  localparam int SKIP_W     = 10;
  localparam int CAP        = 4096;

  logic system_clk = 1'b0;
  logic rst = 1'b1;
  always #5 system_clk = ~system_clk;

  feature_width_conv_fifo_if #(
    .DATA_W(DATA_W), .RATIO_LOG2(RATIO_LOG2), .DEPTH_W(DEPTH_W), .SKIP_W(SKIP_W)
  ) bus ();

  feature_width_conv_fifo #(
    .DATA_W(DATA_W), .RATIO_LOG2(RATIO_LOG2), .DEPTH_W(DEPTH_W),
    .AF_THRESH(128), .AE_THRESH(64), .SKIP_W(SKIP_W)
  ) dut (
    .system_clk(system_clk),
    .rst(rst),
    .bus(bus.slave)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  logic [7:0] exp_q[$];
  int exp_cyc_q[$];
  logic [7:0] mdl_q[$];
  logic [7:0] last_rd = 8'h00;

  always @(posedge system_clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  // Monitor: every o_rdvalid must match the oldest expected lane, one cycle after its request.
  always @(negedge system_clk) begin
    if (exp_cyc_q.size() > 0 && cyc > exp_cyc_q[0]) begin
      checks++;
      errors++;
      $display("FAIL rd_missing: no o_rdvalid at cycle %0d, got none expected data %0h",
               exp_cyc_q[0], exp_q[0]);
      void'(exp_q.pop_front());
      void'(exp_cyc_q.pop_front());
    end
    if (bus.o_rdvalid) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL rd_unexpected: got o_rdvalid data %0h expected no read", bus.o_rddata);
      end else begin
        chk("rd_data", 32'(bus.o_rddata), 32'(exp_q.pop_front()));
        chk("rd_latency", 32'(cyc), 32'(exp_cyc_q.pop_front()));
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
    $fatal(1, "watchdog");
  end

  function automatic logic [127:0] make_word(input logic [7:0] base);
    logic [127:0] w;
    for (int k = 0; k < 16; k++) w[k*8 +: 8] = base + 8'(k);
    return w;
  endfunction

  task automatic tick();
    @(posedge system_clk);
    #1;
    bus.i_clear = 1'b0;
    bus.i_wren  = 1'b0;
    bus.i_rden  = 1'b0;
    bus.i_skip  = 1'b0;
  endtask

  task automatic chk_status(input string tag);
    int sz;
    sz = mdl_q.size();
    chk({tag, " count"}, 32'(bus.o_count), 32'(sz));
    chk({tag, " full"}, 32'(bus.o_full), 32'((CAP - sz) < 16));
    chk({tag, " empty"}, 32'(bus.o_empty), 32'(sz == 0));
    chk({tag, " almost_full"}, 32'(bus.o_almost_full), 32'((sz / 16) >= 128));
    chk({tag, " almost_empty"}, 32'(bus.o_almost_empty), 32'(sz < 64));
  endtask

  // One cycle of stimulus; the model applies skip/read against pre-write contents, then the write.
  task automatic drive(input bit wr, input logic [127:0] d, input bit rd, input bit sk,
                       input logic [9:0] skn, input bit clr, input string tag);
    int sz;
    int n;
    sz = mdl_q.size();
    if (clr) begin
      mdl_q.delete();
    end else begin
      if (sk) begin
        n = (int'(skn) < sz) ? int'(skn) : sz;
        repeat (n) void'(mdl_q.pop_front());
      end else if (rd && sz > 0) begin
        last_rd = mdl_q.pop_front();
        exp_q.push_back(last_rd);
        exp_cyc_q.push_back(cyc + 1);
      end
      if (wr && (CAP - sz) >= 16) begin
        for (int k = 0; k < 16; k++) mdl_q.push_back(d[k*8 +: 8]);
      end
    end
    bus.i_clear    = clr;
    bus.i_wren     = wr;
    bus.i_wrdata   = d;
    bus.i_rden     = rd;
    bus.i_skip     = sk;
    bus.i_skip_num = skn;
    tick();
    chk_status(tag);
  endtask

  task automatic do_reset(input bit wr);
    rst = 1'b1;
    bus.i_wren = wr;
    bus.i_wrdata = make_word(8'h77);
    bus.i_clear = 1'b1;
    tick();
    rst = 1'b0;
    mdl_q.delete();
  endtask

  initial begin
    logic [127:0] w;
    int nw;
    bus.i_clear    = 1'b0;
    bus.i_wren     = 1'b0;
    bus.i_wrdata   = '0;
    bus.i_rden     = 1'b0;
    bus.i_skip     = 1'b0;
    bus.i_skip_num = '0;
    repeat (2) tick();
    do_reset(1'b0);

    // Reset state
    chk("reset count", 32'(bus.o_count), 0);
    chk("reset empty", 32'(bus.o_empty), 1);
    chk("reset full", 32'(bus.o_full), 0);
    chk("reset almost_empty", 32'(bus.o_almost_empty), 1);
    chk("reset almost_full", 32'(bus.o_almost_full), 0);
    chk("reset rddata", 32'(bus.o_rddata), 0);
    chk("reset rdvalid", 32'(bus.o_rdvalid), 0);

    // One word, lanes 0x00..0x0F, read back-to-back
    drive(1'b1, make_word(8'h00), 1'b0, 1'b0, '0, 1'b0, "t1 write");
    chk("t1 count after write", 32'(bus.o_count), 16);
    for (int i = 0; i < 16; i++) begin
      drive(1'b0, '0, 1'b1, 1'b0, '0, 1'b0, "t1 read");
      chk("t1 lane", 32'(bus.o_rddata), 32'(i));
    end
    chk("t1 empty at end", 32'(bus.o_empty), 1);
    drive(1'b0, '0, 1'b1, 1'b0, '0, 1'b0, "t1 read empty");

    // Fill to capacity, drop the extra write, drain until not full
    for (int i = 0; i < 256; i++) drive(1'b1, make_word(8'(i)), 1'b0, 1'b0, '0, 1'b0, "t2 fill");
    chk("t2 full count", 32'(bus.o_count), 4096);
    chk("t2 full flag", 32'(bus.o_full), 1);
    drive(1'b1, make_word(8'hEE), 1'b0, 1'b0, '0, 1'b0, "t2 drop");
    chk("t2 dropped count", 32'(bus.o_count), 4096);
    drive(1'b0, '0, 1'b1, 1'b0, '0, 1'b0, "t2 read");
    chk("t2 count after read", 32'(bus.o_count), 4095);
    chk("t2 full after read", 32'(bus.o_full), 1);
    for (int i = 1; i < 16; i++) drive(1'b0, '0, 1'b1, 1'b0, '0, 1'b0, "t2 drain");
    chk("t2 not full after 16 reads", 32'(bus.o_full), 0);
    drive(1'b0, '0, 1'b0, 1'b0, '0, 1'b1, "t2 clear");

    // Skip, skip with read (skip wins), read after skip, oversize skip
    drive(1'b1, make_word(8'h10), 1'b0, 1'b0, '0, 1'b0, "t3 write0");
    drive(1'b1, make_word(8'h20), 1'b0, 1'b0, '0, 1'b0, "t3 write1");
    drive(1'b0, '0, 1'b0, 1'b1, 10'd5, 1'b0, "t3 skip5");
    chk("t3 count after skip5", 32'(bus.o_count), 27);
    drive(1'b0, '0, 1'b1, 1'b1, 10'd0, 1'b0, "t3 skip+read");
    chk("t3 rdvalid on skip+read", 32'(bus.o_rdvalid), 0);
    chk("t3 count after skip+read", 32'(bus.o_count), 27);
    drive(1'b0, '0, 1'b1, 1'b0, '0, 1'b0, "t3 read");
    chk("t3 word0 lane5", 32'(bus.o_rddata), 32'h15);
    drive(1'b0, '0, 1'b0, 1'b1, 10'd100, 1'b0, "t3 skip100");
    chk("t3 count after skip100", 32'(bus.o_count), 0);
    chk("t3 rddata held", 32'(bus.o_rddata), 32'h15);

    // Simultaneous write and read with one lane left
    drive(1'b1, make_word(8'h30), 1'b0, 1'b0, '0, 1'b0, "t4 write");
    for (int i = 0; i < 15; i++) drive(1'b0, '0, 1'b1, 1'b0, '0, 1'b0, "t4 read");
    chk("t4 count one left", 32'(bus.o_count), 1);
    drive(1'b1, make_word(8'h40), 1'b1, 1'b0, '0, 1'b0, "t4 wr+rd");
    chk("t4 count after wr+rd", 32'(bus.o_count), 16);
    chk("t4 last lane of word A", 32'(bus.o_rddata), 32'h3F);
    drive(1'b0, '0, 1'b1, 1'b0, '0, 1'b0, "t4 read B0");
    chk("t4 first lane of word B", 32'(bus.o_rddata), 32'h40);

    // Continuous wrap across both pointer boundaries
    drive(1'b0, '0, 1'b0, 1'b0, '0, 1'b1, "t5 clear");
    nw = 0;
    while (nw < 300 || mdl_q.size() > 0) begin
      w = {$urandom, $urandom, $urandom, $urandom};
      if (nw < 300 && (CAP - mdl_q.size()) >= 16) begin
        drive(1'b1, w, 1'b1, 1'b0, '0, 1'b0, "t5 wr+rd");
        nw++;
      end else begin
        drive(1'b0, w, 1'b1, 1'b0, '0, 1'b0, "t5 rd");
      end
    end
    chk("t5 empty after wrap", 32'(bus.o_empty), 1);

    // Clear with cnt=50 and a write pending
    for (int i = 0; i < 4; i++) drive(1'b1, make_word(8'(8'h50 + 8'(i * 16))), 1'b0, 1'b0, '0, 1'b0, "t6 fill");
    drive(1'b0, '0, 1'b1, 1'b0, '0, 1'b0, "t6 read");
    drive(1'b0, '0, 1'b0, 1'b1, 10'd13, 1'b0, "t6 skip");
    chk("t6 count 50", 32'(bus.o_count), 50);
    drive(1'b1, make_word(8'h99), 1'b1, 1'b0, '0, 1'b1, "t6 clear");
    chk("t6 clear count", 32'(bus.o_count), 0);
    chk("t6 clear empty", 32'(bus.o_empty), 1);
    chk("t6 clear almost_empty", 32'(bus.o_almost_empty), 1);
    chk("t6 clear rdvalid", 32'(bus.o_rdvalid), 0);
    chk("t6 clear keeps rddata", 32'(bus.o_rddata), 32'h50);

    // Reset with cnt=50 and a write pending
    for (int i = 0; i < 4; i++) drive(1'b1, make_word(8'(8'hA0 + 8'(i * 16))), 1'b0, 1'b0, '0, 1'b0, "t7 fill");
    drive(1'b0, '0, 1'b1, 1'b0, '0, 1'b0, "t7 read");
    drive(1'b0, '0, 1'b0, 1'b1, 10'd13, 1'b0, "t7 skip");
    chk("t7 count 50", 32'(bus.o_count), 50);
    do_reset(1'b1);
    chk("t7 reset count", 32'(bus.o_count), 0);
    chk("t7 reset empty", 32'(bus.o_empty), 1);
    chk("t7 reset almost_empty", 32'(bus.o_almost_empty), 1);
    chk("t7 reset rdvalid", 32'(bus.o_rdvalid), 0);
    chk("t7 reset rddata", 32'(bus.o_rddata), 0);
    drive(1'b0, '0, 1'b1, 1'b0, '0, 1'b0, "t7 read after reset");

    repeat (3) tick();
    chk("pending reads", 32'(exp_q.size()), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
